// File: rtl/cpu_pkg.sv
// Shared opcode map and sequencer encodings for the single-bus CPU.
// Opcodes are common to the datapath ALU, the control unit and the benches.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  typedef enum logic [3:0] {
    ST_RESET  = 4'd0,
    ST_T0     = 4'd1,
    ST_T1     = 4'd2,
    ST_T2     = 4'd3,
    ST_T3     = 4'd4,
    ST_T4     = 4'd5,
    ST_T5     = 4'd6,
    ST_T6     = 4'd7,
    ST_T7     = 4'd8,
    ST_HALTED = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    CL_RTYPE,
    CL_IMM,
    CL_LDI,
    CL_LD,
    CL_ST,
    CL_BR,
    CL_SINGLE,
    CL_NOP,
    CL_HALT
  } op_class_t;

endpackage

// File: rtl/op_class_decode.sv
// Opcode classifier: groups opcodes that share an execute sequence and
// resolves the ALU operation those sequences request.
import cpu_pkg::*;

module op_class_decode (
  input  logic [4:0] opcode,
  output op_class_t  op_class,
  output logic [4:0] alu_op
);

  always_comb begin
    op_class = CL_NOP;
    alu_op   = 5'b00000;
    case (opcode)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_AND, OP_OR: begin
        op_class = CL_RTYPE;
        alu_op   = opcode;
      end
      OP_ADDI: begin op_class = CL_IMM; alu_op = OP_ADD; end
      OP_ANDI: begin op_class = CL_IMM; alu_op = OP_AND; end
      OP_ORI:  begin op_class = CL_IMM; alu_op = OP_OR;  end
      // address/offset arithmetic all goes through the adder
      OP_LDI:  begin op_class = CL_LDI; alu_op = OP_ADD; end
      OP_LD:   begin op_class = CL_LD;  alu_op = OP_ADD; end
      OP_ST:   begin op_class = CL_ST;  alu_op = OP_ADD; end
      OP_BR:   begin op_class = CL_BR;  alu_op = OP_ADD; end
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: op_class = CL_SINGLE;
      OP_HALT: op_class = CL_HALT;
      default: op_class = CL_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer driving the single-bus datapath strobes.
// state   | meaning
// RESET   | held by Clear, all strobes low
// T0..T2  | instruction fetch
// T3..T7  | execute, sequence chosen by opcode class
// HALTED  | parked after halt until Clear
import cpu_pkg::*;

module control_unit (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        BranchMet,
  output logic        PCout,
  output logic        Zhiout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        InPortout,
  output logic        HIout,
  output logic        LOout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        OutPortin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        CONin,
  output logic [4:0]  alu_op,
  output logic        Run
);

  state_t     state, state_nxt;
  op_class_t  op_class;
  logic [4:0] class_alu;
  logic [4:0] opcode;
  logic       unused_ir_fields;

  assign opcode           = IR[31:27];
  assign unused_ir_fields = ^IR[26:0];

  op_class_decode u_decode (
    .opcode   (opcode),
    .op_class (op_class),
    .alu_op   (class_alu)
  );

  always_ff @(posedge Clock) begin
    if (Clear) state <= ST_RESET;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    {PCout, Zhiout, Zlowout, MDRout, InPortout, HIout, LOout} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin}          = '0;
    {IncPC, Read, Write}                                     = '0;
    {Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin}           = '0;
    alu_op = 5'b00000;
    Run    = (state != ST_RESET) && (state != ST_HALTED);

    case (state)
      ST_RESET: state_nxt = ST_T0;
      ST_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        state_nxt = ST_T1;
      end
      ST_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        state_nxt = ST_T2;
      end
      ST_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        // nop/halt are resolved here so they skip the execute steps entirely
        case (op_class)
          CL_NOP:  state_nxt = ST_T0;
          CL_HALT: state_nxt = ST_HALTED;
          default: state_nxt = ST_T3;
        endcase
      end
      ST_T3: begin
        state_nxt = ST_T4;
        case (op_class)
          CL_RTYPE, CL_IMM: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CL_LDI, CL_LD, CL_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          CL_BR: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          CL_SINGLE: begin
            state_nxt = ST_T0;
            case (opcode)
              OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
              OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
              OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              default: ;
            endcase
          end
          default: state_nxt = ST_T0;
        endcase
      end
      ST_T4: begin
        state_nxt = ST_T5;
        case (op_class)
          CL_RTYPE: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = class_alu; end
          CL_IMM, CL_LDI, CL_LD, CL_ST: begin Cout = 1'b1; Zin = 1'b1; alu_op = class_alu; end
          CL_BR: begin PCout = 1'b1; Yin = 1'b1; end
          default: state_nxt = ST_T0;
        endcase
      end
      ST_T5: begin
        state_nxt = ST_T0;
        case (op_class)
          CL_RTYPE, CL_IMM, CL_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_LD, CL_ST: begin Zlowout = 1'b1; MARin = 1'b1; state_nxt = ST_T6; end
          CL_BR: begin Cout = 1'b1; Zin = 1'b1; alu_op = class_alu; state_nxt = ST_T6; end
          default: ;
        endcase
      end
      ST_T6: begin
        state_nxt = ST_T0;
        case (op_class)
          CL_LD: begin Read = 1'b1; MDRin = 1'b1; state_nxt = ST_T7; end
          // Read stays low so MDR captures the register value from the bus
          CL_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; state_nxt = ST_T7; end
          CL_BR: begin Zlowout = 1'b1; PCin = BranchMet; end
          default: ;
        endcase
      end
      ST_T7: begin
        state_nxt = ST_T0;
        case (op_class)
          CL_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_ST: Write = 1'b1;
          default: ;
        endcase
      end
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_RESET;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-cycle comparison against an instruction-level
// model of the strobe sequence, with random programs and directed pins.
module tb_control_unit;

  typedef struct packed {
    logic PCout, Zhiout, Zlowout, MDRout, InPortout, HIout, LOout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin;
    logic IncPC, Read, Write;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin;
    logic Run;
    logic [4:0] alu_op;
  } ctl_t;

  logic        Clock = 1'b0;
  logic        Clear;
  logic [31:0] IR;
  logic        BranchMet;
  ctl_t        act;

  control_unit dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .BranchMet(BranchMet),
    .PCout(act.PCout), .Zhiout(act.Zhiout), .Zlowout(act.Zlowout),
    .MDRout(act.MDRout), .InPortout(act.InPortout), .HIout(act.HIout),
    .LOout(act.LOout), .MARin(act.MARin), .Zin(act.Zin), .PCin(act.PCin),
    .MDRin(act.MDRin), .IRin(act.IRin), .Yin(act.Yin), .OutPortin(act.OutPortin),
    .IncPC(act.IncPC), .Read(act.Read), .Write(act.Write), .Gra(act.Gra),
    .Grb(act.Grb), .Grc(act.Grc), .Rin(act.Rin), .Rout(act.Rout),
    .BAout(act.BAout), .Cout(act.Cout), .CONin(act.CONin),
    .alu_op(act.alu_op), .Run(act.Run)
  );

  always #5 Clock = ~Clock;

  int   n_assert = 0;
  int   n_fail   = 0;
  logic chk_en   = 1'b0;
  logic pin_en   = 1'b0;
  ctl_t exp_c, pin_m, pin_v;
  string pin_name = "";
  int   cur_step = 0;

  // Instruction-level model: what the spec says each step of an opcode drives.
  function automatic int latency(input logic [4:0] op);
    if (op inside {5'd0, 5'd2})                                     return 8;
    if (op == 5'd18)                                                return 7;
    if (op inside {5'd1, 5'd3, 5'd4, 5'd5, 5'd6, 5'd9, 5'd10,
                   5'd11, 5'd12, 5'd13})                            return 6;
    if (op inside {5'd19, 5'd21, 5'd22, 5'd23, 5'd24})              return 4;
    return 3;
  endfunction

  function automatic ctl_t exp_step(input int k, input logic [4:0] op, input logic bm);
    ctl_t c;
    logic rt, im, ad;
    c = '0;
    c.Run = 1'b1;
    rt = op inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd9, 5'd10};
    im = op inside {5'd11, 5'd12, 5'd13};
    ad = op inside {5'd0, 5'd1, 5'd2};
    case (k)
      0: begin c.PCout = 1; c.MARin = 1; c.IncPC = 1; c.Zin = 1; end
      1: begin c.Zlowout = 1; c.PCin = 1; c.Read = 1; c.MDRin = 1; end
      2: begin c.MDRout = 1; c.IRin = 1; end
      3: begin
        if (rt || im) begin c.Grb = 1; c.Rout = 1; c.Yin = 1; end
        else if (ad) begin c.Grb = 1; c.BAout = 1; c.Yin = 1; end
        else if (op == 5'd18) begin c.Gra = 1; c.Rout = 1; c.CONin = 1; end
        else if (op == 5'd19) begin c.Gra = 1; c.Rout = 1; c.PCin = 1; end
        else if (op == 5'd21) begin c.InPortout = 1; c.Gra = 1; c.Rin = 1; end
        else if (op == 5'd22) begin c.Gra = 1; c.Rout = 1; c.OutPortin = 1; end
        else if (op == 5'd23) begin c.HIout = 1; c.Gra = 1; c.Rin = 1; end
        else if (op == 5'd24) begin c.LOout = 1; c.Gra = 1; c.Rin = 1; end
      end
      4: begin
        if (rt) begin c.Grc = 1; c.Rout = 1; c.Zin = 1; c.alu_op = op; end
        else if (im) begin
          c.Cout = 1; c.Zin = 1;
          c.alu_op = (op == 5'd11) ? 5'd3 : (op == 5'd12) ? 5'd9 : 5'd10;
        end
        else if (ad) begin c.Cout = 1; c.Zin = 1; c.alu_op = 5'd3; end
        else if (op == 5'd18) begin c.PCout = 1; c.Yin = 1; end
      end
      5: begin
        if (rt || im || op == 5'd1) begin c.Zlowout = 1; c.Gra = 1; c.Rin = 1; end
        else if (ad) begin c.Zlowout = 1; c.MARin = 1; end
        else if (op == 5'd18) begin c.Cout = 1; c.Zin = 1; c.alu_op = 5'd3; end
      end
      6: begin
        if (op == 5'd0) begin c.Read = 1; c.MDRin = 1; end
        else if (op == 5'd2) begin c.Gra = 1; c.Rout = 1; c.MDRin = 1; end
        else if (op == 5'd18) begin c.Zlowout = 1; c.PCin = bm; end
      end
      7: begin
        if (op == 5'd0) begin c.MDRout = 1; c.Gra = 1; c.Rin = 1; end
        else if (op == 5'd2) c.Write = 1;
      end
      default: ;
    endcase
    return c;
  endfunction

  always @(negedge Clock) begin
    if (chk_en) begin
      n_assert++;
      if (act !== exp_c) begin
        n_fail++;
        $display("FAIL ctl_vector t=%0t step=%0d IR=%h actual=%h required=%h",
                 $time, cur_step, IR, act, exp_c);
      end
      n_assert++;
      if (act.Read === 1'b1 && act.Write === 1'b1) begin
        n_fail++;
        $display("FAIL read_write_excl t=%0t actual=11 required=not both", $time);
      end
      if (pin_en) begin
        n_assert++;
        if ((act & pin_m) !== pin_v) begin
          n_fail++;
          $display("FAIL pin_%s t=%0t actual=%h required=%h", pin_name, $time,
                   act & pin_m, pin_v);
        end
      end
    end
  end

  // Entered at T0+1; returns at the following T0+1 (or RESET/HALTED+1).
  task automatic run_instr(input logic [31:0] ir, input logic bm, input int clr_at,
                           input string pn, input int pk, input ctl_t pm, input ctl_t pv);
    int len;
    IR = ir;
    BranchMet = bm;
    len = latency(ir[31:27]);
    for (int k = 0; k < len; k++) begin
      if (k > 0) @(posedge Clock) #1;
      cur_step = k;
      exp_c = exp_step(k, ir[31:27], bm);
      pin_en = (k == pk);
      pin_name = pn; pin_m = pm; pin_v = pv;
      if (k == clr_at) begin
        Clear = 1'b1;
        break;
      end
    end
    @(posedge Clock) #1;
    pin_en = 1'b0;
    if (clr_at >= 0 && clr_at < len) begin
      cur_step = -1;
      exp_c = '0;
      pin_en = 1'b1; pin_name = "abort_no_mem";
      pin_m = '0; pin_m.Read = 1; pin_m.MDRin = 1; pin_m.Write = 1;
      pin_v = '0;
      Clear = 1'b0;
      @(posedge Clock) #1;
      pin_en = 1'b0;
    end
  endtask

  ctl_t all_m, v;
  int   op_r;

  initial begin
    Clear = 1'b1; IR = '0; BranchMet = 1'b0;
    all_m = '1;
    exp_c = '0; pin_m = '0; pin_v = '0;

    // reset: two Clear edges, then the first T0
    @(posedge Clock) #1;
    cur_step = -1; exp_c = '0; chk_en = 1'b1;
    pin_en = 1'b1; pin_name = "reset_zero"; pin_m = all_m; pin_v = '0;
    @(posedge Clock) #1;
    exp_c = '0;
    Clear = 1'b0;
    @(posedge Clock) #1;
    pin_en = 1'b0;

    v = '0; v.PCout = 1; v.MARin = 1; v.IncPC = 1; v.Zin = 1; v.Run = 1;
    run_instr(32'h18918000, 1'b0, -1, "first_t0", 0, all_m, v);

    v = '0; v.Grc = 1; v.Rout = 1; v.Zin = 1; v.Run = 1; v.alu_op = 5'b00011;
    run_instr(32'h18918000, 1'b0, -1, "add_t4", 4, all_m, v);

    v = '0; v.Gra = 1; v.Rout = 1; v.CONin = 1; v.Run = 1;
    run_instr(32'h91100023, 1'b1, -1, "br_t3", 3, all_m, v);
    v = '0; v.Zlowout = 1; v.PCin = 1; v.Run = 1;
    run_instr(32'h91100023, 1'b1, -1, "br_taken_t6", 6, all_m, v);
    v = '0; v.Zlowout = 1; v.Run = 1;
    run_instr(32'h91100023, 1'b0, -1, "br_not_taken_t6", 6, all_m, v);

    v = '0; v.Gra = 1; v.Rout = 1; v.MDRin = 1; v.Run = 1;
    run_instr(32'h10900057, 1'b0, -1, "st_t6", 6, all_m, v);
    v = '0; v.Write = 1; v.Run = 1;
    run_instr(32'h10900057, 1'b0, -1, "st_t7", 7, all_m, v);

    // mid-op Clear on ld: Clear seen at the edge that would enter T5
    run_instr(32'h00900010, 1'b0, 4, "none", -1, '0, '0);
    v = '0; v.PCout = 1; v.MARin = 1; v.IncPC = 1; v.Zin = 1; v.Run = 1;
    run_instr(32'hC8000000, 1'b0, -1, "t0_after_clear", 0, all_m, v);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] ir;
      int lat, ca;
      op_r = $urandom_range(0, 31);
      if (op_r == 26) op_r = 25;
      ir = {op_r[4:0], 27'($urandom)};
      lat = latency(ir[31:27]);
      ca = ($urandom_range(0, 7) == 0) ? $urandom_range(0, lat - 1) : -1;
      run_instr(ir, 1'($urandom_range(0, 1)), ca, "none", -1, '0, '0);
    end

    // halt parks for 20 cycles, Clear returns through RESET to T0
    run_instr(32'hD0000000, 1'b0, -1, "none", -1, '0, '0);
    for (int i = 0; i < 20; i++) begin
      cur_step = -2;
      exp_c = '0;
      pin_en = 1'b1; pin_name = "halted_idle"; pin_m = all_m; pin_v = '0;
      if (i == 19) Clear = 1'b1;
      @(posedge Clock) #1;
    end
    pin_en = 1'b0;
    cur_step = -1; exp_c = '0; Clear = 1'b0;
    @(posedge Clock) #1;
    v = '0; v.PCout = 1; v.MARin = 1; v.IncPC = 1; v.Zin = 1; v.Run = 1;
    run_instr(32'h58918000, 1'b0, -1, "t0_after_halt", 0, all_m, v);

    chk_en = 1'b0;
    @(posedge Clock) #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
